matrix_row_mover: RTL and testbench
===================================

# matrix_row_mover

Initiator side of the Jacobi matrix row store. It converts a 32-bit word stream into 1024-bit rows and writes them to the single-port row RAM. It also reads rows back and emits them as a 32-bit word stream. It sits between the host/matrix I/O path and the row RAM port, and owns `ena`, `read_write`, the address and the write data, while honouring the RAM's one-cycle read latency.

## Interface
- `WORD_W`, 32, element width in bits
- `WORDS_PER_ROW`, 32, elements per RAM row (row width = 1024)
- `ADDR_W`, 5, RAM row address width (32 rows)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_write`  in  1  1 = load stream into RAM, 0 = dump RAM to stream
- `cmd_row_start`  in  ADDR_W  first row
- `cmd_row_count`  in  ADDR_W+1  rows to move, 0..32
- `s_data`  in  WORD_W  input word (write commands)
- `s_valid` / `s_ready`  in / out  1  input handshake
- `m_data`  out  WORD_W  output word (read commands)
- `m_valid` / `m_ready`  out / in  1  output handshake
- `ram_ena`  out  1  RAM enable
- `ram_we`  out  1  1 = write, 0 = read
- `ram_addr`  out  ADDR_W  row address
- `ram_din`  out  1024  row write data
- `ram_dout`  in  1024  row read data, valid the cycle after a read enable
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse when a command completes

## Operation
- Reset values: `cmd_ready` 1, `ram_ena` 0, `ram_we` 0, `ram_addr` 0, `ram_din` 0, `s_ready` 0, `m_valid` 0, `m_data` 0, `busy` 0, `done` 0.
- Command handshake: a command is accepted on `cmd_valid & cmd_ready`. Start row and count are latched; the row pointer is a 5-bit counter that wraps 31→0.
- Word/row mapping: word k occupies bits [32k+31:32k]. Word 0 is first on both streams.
- FSM states: IDLE, FILL, WRITE, RD_REQ, RD_CAP, DRAIN, FIN.
- IDLE: on accept, go to FIN if count = 0; else go to FILL if `cmd_write`; else go to RD_REQ.
- FILL:
  - `s_ready` = 1.
  - Each `s_valid & s_ready` shifts `s_data` into the pack register and increments the word counter.
  - The 32nd word moves the FSM to WRITE.
- WRITE:
  - One cycle with `ram_ena`=1, `ram_we`=1, `ram_addr`=row pointer, `ram_din`=packed row, `s_ready`=0.
  - Then increment the row pointer and decrement rows remaining.
  - Rows remaining > 0 → FILL; else → FIN.
- RD_REQ: one cycle with `ram_ena`=1, `ram_we`=0, `ram_addr`=row pointer.
- RD_CAP: `ram_ena`=0; `ram_dout` is latched into the unpack register.
- DRAIN:
  - `m_valid` = 1 and `m_data` = word at the current index.
  - Each `m_valid & m_ready` advances the index.
  - The 32nd handshake increments the row pointer; rows remaining > 0 → RD_REQ, else → FIN.
  - `m_data` is held stable while `m_valid & !m_ready`.
- FIN: `done` = 1 for one cycle, then IDLE.
- `ram_ena` is 0 in every state except WRITE and RD_REQ. The RAM is therefore never written with a partial row.
- Reset mid-command: the partial row is discarded, no RAM access occurs, and the next command starts cleanly.
- `cmd_valid` during `busy` is ignored. It is not queued.

## Timing
- Write, full-rate stream: 33 cycles per row (32 FILL + 1 WRITE), plus 1 FIN cycle per command.
- Read: the first `m_valid` is 2 cycles after entering RD_REQ. With `m_ready` held high, each row takes 34 cycles (RD_REQ + RD_CAP + 32 DRAIN).
- `done` is asserted the cycle after the last RAM write, or the cycle after the last output handshake.
- Count = 0: `done` is asserted the cycle after accept, with no RAM access.
- Back-to-back commands: `cmd_ready` returns the cycle after `done`.

## Structure
- Shared package `jacobi_pkg`:
  - `WORD_W`, `WORDS_PER_ROW`, `ADDR_W`, `ROW_W` (= `WORD_W`*`WORDS_PER_ROW`)
  - the FSM state enum
  - the word-slice helper function
- Sub-module `row_shifter`: a 1024-bit register with parallel load, shift-in of one word at the top with shift-down, and the bottom word as output. One instance is used for pack (FILL) and also for unpack (RD_CAP load, DRAIN shift). This sharing is legal because FILL and DRAIN are mutually exclusive.

## Test plan
- Write start 0, count 1, words 0..31 at full rate → a single WRITE cycle at addr 0 with `ram_din` word k = k; `done` at cycle 34 after accept.
- Read start 0, count 1, behavioural 1-cycle-latency RAM preloaded as above → `m_data` sequence 0..31. Apply random `m_ready` stalls; `m_data` must be stable during stalls.
- Write start 30, count 4 → WRITE addresses 30, 31, 0, 1 in order. Read back with the same start and count → identical 128-word stream.
- Count = 0 for read and for write → `done` the cycle after accept, `ram_ena` never high.
- Drop `reset` low after 10 words of a write, then release and write start 5, count 1 → no RAM write before the new command; row 5 holds only the new words.
- `s_valid` gaps of 1–3 cycles during FILL → exactly one WRITE per 32 accepted words, and `s_ready` low during WRITE.

Source files
------------

// File: rtl/matrix_row_mover_pkg.sv
// Shared widths, FSM state encoding and the row/word slicing helper for the row mover.
package matrix_row_mover_pkg;
   localparam int WORD_W        = 32;
   localparam int WORDS_PER_ROW = 32;
   localparam int ADDR_W        = 5;
   localparam int ROW_W         = WORD_W * WORDS_PER_ROW;
   localparam int IDX_W         = $clog2(WORDS_PER_ROW);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_WRITE,
      ST_RD_REQ,
      ST_RD_CAP,
      ST_DRAIN,
      ST_FIN
   } state_t;

   // Word k of a row lives at bits [WORD_W*k +: WORD_W].
   function automatic logic [WORD_W-1:0] word_slice(input logic [ROW_W-1:0] row,
                                                    input int unsigned k);
      return WORD_W'(row >> (k * WORD_W));
   endfunction
endpackage

// File: rtl/matrix_row_mover_if.sv
// Command, word-stream and row-RAM signals of the row mover; master is the mover itself.
interface matrix_row_mover_if;
   import matrix_row_mover_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_write;
   logic [ADDR_W-1:0]   cmd_row_start;
   logic [ADDR_W:0]     cmd_row_count;
   logic [WORD_W-1:0]   s_data;
   logic                s_valid;
   logic                s_ready;
   logic [WORD_W-1:0]   m_data;
   logic                m_valid;
   logic                m_ready;
   logic                ram_ena;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [ROW_W-1:0]    ram_din;
   logic [ROW_W-1:0]    ram_dout;
   logic                busy;
   logic                done;

   modport master (
      input  cmd_valid, cmd_write, cmd_row_start, cmd_row_count,
      input  s_data, s_valid, m_ready, ram_dout,
      output cmd_ready, s_ready, m_data, m_valid,
      output ram_ena, ram_we, ram_addr, ram_din, busy, done
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_row_start, cmd_row_count,
      output s_data, s_valid, m_ready, ram_dout,
      input  cmd_ready, s_ready, m_data, m_valid,
      input  ram_ena, ram_we, ram_addr, ram_din, busy, done
   );
endinterface

// File: rtl/matrix_row_mover_row_shifter.sv
// Row-wide register: parallel load, or shift one word in at the top while shifting down.
module matrix_row_mover_row_shifter
   import matrix_row_mover_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [ROW_W-1:0]    load_data,
   input  logic                shift,
   input  logic [WORD_W-1:0]   shift_in,
   output logic [ROW_W-1:0]    data,
   output logic [WORD_W-1:0]   bottom
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift) begin
         data <= {shift_in, data[ROW_W-1:WORD_W]};
      end
   end

   assign bottom = word_slice(data, 0);
endmodule

// File: rtl/matrix_row_mover.sv
// Row mover: packs a word stream into RAM rows, and unpacks RAM rows into a word stream.
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// FILL    | accepting input words into the pack register
// WRITE   | single-cycle RAM write of the packed row
// RD_REQ  | single-cycle RAM read request
// RD_CAP  | RAM read data captured into the unpack register
// DRAIN   | emitting the captured row one word per handshake
// FIN     | one-cycle done pulse
module matrix_row_mover
   import matrix_row_mover_pkg::*;
(
   input  logic clk,
   input  logic reset,
   matrix_row_mover_if.master bus
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_ROW - 1);
   localparam logic [ADDR_W:0]  ONE_ROW  = 1;

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  row_ptr;
   logic [ADDR_W:0]    rows_left;
   logic [IDX_W-1:0]   word_left;
   logic               accept, s_fire, m_fire, word_tc, row_tc, row_step;
   logic               sh_load, sh_shift;
   logic [ROW_W-1:0]   sh_data;
   logic [WORD_W-1:0]  sh_bottom;

   assign accept   = (state == ST_IDLE) && bus.cmd_valid;
   assign s_fire   = (state == ST_FILL) && bus.s_valid;
   assign m_fire   = (state == ST_DRAIN) && bus.m_ready;
   assign word_tc  = (word_left == '0);
   assign row_tc   = (rows_left == ONE_ROW);
   assign row_step = (state == ST_WRITE) || (m_fire && word_tc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (bus.cmd_row_count == '0) begin
                  state_nxt = ST_FIN;
               end else if (bus.cmd_write) begin
                  state_nxt = ST_FILL;
               end else begin
                  state_nxt = ST_RD_REQ;
               end
            end
         end
         ST_FILL:   if (s_fire && word_tc) state_nxt = ST_WRITE;
         ST_WRITE:  state_nxt = row_tc ? ST_FIN : ST_FILL;
         ST_RD_REQ: state_nxt = ST_RD_CAP;
         ST_RD_CAP: state_nxt = ST_DRAIN;
         ST_DRAIN:  if (m_fire && word_tc) state_nxt = row_tc ? ST_FIN : ST_RD_REQ;
         ST_FIN:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = 1'b0;
      bus.busy      = 1'b1;
      bus.s_ready   = 1'b0;
      bus.m_valid   = 1'b0;
      bus.ram_ena   = 1'b0;
      bus.ram_we    = 1'b0;
      bus.done      = 1'b0;
      sh_load       = 1'b0;
      sh_shift      = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
            bus.busy      = 1'b0;
         end
         ST_FILL: begin
            bus.s_ready = 1'b1;
            sh_shift    = s_fire;
         end
         ST_WRITE: begin
            bus.ram_ena = 1'b1;
            bus.ram_we  = 1'b1;
         end
         ST_RD_REQ: bus.ram_ena = 1'b1;
         ST_RD_CAP: sh_load = 1'b1;
         ST_DRAIN: begin
            bus.m_valid = 1'b1;
            sh_shift    = m_fire;
         end
         ST_FIN:  bus.done = 1'b1;
         default: ;
      endcase
   end

   // Word counter runs down to zero once per row and reloads for the next row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_ptr   <= '0;
         rows_left <= '0;
         word_left <= LAST_IDX;
      end else if (accept) begin
         row_ptr   <= bus.cmd_row_start;
         rows_left <= bus.cmd_row_count;
         word_left <= LAST_IDX;
      end else begin
         if (s_fire || m_fire) begin
            word_left <= word_tc ? LAST_IDX : word_left - IDX_W'(1);
         end
         if (row_step) begin
            row_ptr   <= row_ptr + ADDR_W'(1);
            rows_left <= rows_left - ONE_ROW;
         end
      end
   end

   // One register serves as pack buffer in FILL and unpack buffer in DRAIN.
   matrix_row_mover_row_shifter u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load      (sh_load),
      .load_data (bus.ram_dout),
      .shift     (sh_shift),
      .shift_in  (bus.s_data),
      .data      (sh_data),
      .bottom    (sh_bottom)
   );

   assign bus.ram_addr = row_ptr;
   assign bus.ram_din  = sh_data;
   assign bus.m_data   = sh_bottom;
endmodule

// File: tb/tb_matrix_row_mover.sv
// Bench for matrix_row_mover: behavioural row RAM, bus monitor and a word-level reference store.
module tb_matrix_row_mover;
   import matrix_row_mover_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matrix_row_mover_if bus();
   matrix_row_mover dut (.clk(clk), .reset(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;

   // Single-port row RAM with one-cycle read latency.
   logic [ROW_W-1:0] mem [32];
   always @(posedge clk) begin
      if (bus.ram_ena) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
         else            bus.ram_dout      <= mem[bus.ram_addr];
      end
   end

   // Reference: what each row should hold, word by word, and the words of the current command.
   logic [31:0] ref_words [32][32];
   logic [31:0] exp_w [$];
   logic [31:0] tx_q [$];

   // Monitor, sampled mid-cycle.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int acc_cyc = -1, done_cyc = -1, first_mv_cyc = -1;
   int s_cnt = 0, stall_viol = 0, sready_viol = 0;
   logic [4:0]       ev_addr [$];
   bit               ev_we   [$];
   logic [ROW_W-1:0] ev_din  [$];
   int               ev_cyc  [$];
   logic [31:0]      out_q   [$];
   bit               prev_stall = 1'b0;
   logic [31:0]      prev_data  = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.cmd_valid && bus.cmd_ready) begin
            acc_cyc      = cyc;
            first_mv_cyc = -1;
         end
         if (bus.done) done_cyc = cyc;
         if (bus.ram_ena) begin
            ev_addr.push_back(bus.ram_addr);
            ev_we.push_back(bus.ram_we);
            ev_din.push_back(bus.ram_din);
            ev_cyc.push_back(cyc);
         end
         if (bus.s_valid && bus.s_ready) s_cnt++;
         if (bus.ram_ena && bus.s_ready) sready_viol++;
         if (bus.m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
         if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stall_viol++;
         if (bus.m_valid && bus.m_ready) out_q.push_back(bus.m_data);
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input bit wr, input int start, input int count, output bit to);
      bus.cmd_valid     = 1'b1;
      bus.cmd_write     = wr;
      bus.cmd_row_start = start[ADDR_W-1:0];
      bus.cmd_row_count = count[ADDR_W:0];
      to = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            to = 1'b0;
            break;
         end
      end
      step();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_words(input bit gaps, output bit to);
      int n;
      to = 1'b0;
      while (tx_q.size() > 0) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            bus.s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
         end
         bus.s_valid = 1'b1;
         bus.s_data  = tx_q.pop_front();
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.s_ready && n < 100);
         if (!bus.s_ready) begin
            to = 1'b1;
            bus.s_valid = 1'b0;
            return;
         end
         step();
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_done(output bit to);
      to = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.done) begin
            to = 1'b0;
            break;
         end
      end
      #1;
   endtask

   task automatic run_write(input int start, input int count, input bit gaps, input bit ramp,
                            output bit to);
      bit t1, t2, t3;
      logic [31:0] w;
      exp_w.delete();
      tx_q.delete();
      for (int r = 0; r < count; r++) begin
         for (int k = 0; k < 32; k++) begin
            w = ramp ? 32'(r * 32 + k) : 32'($urandom());
            exp_w.push_back(w);
            tx_q.push_back(w);
            ref_words[(start + r) % 32][k] = w;
         end
      end
      bus.m_ready = 1'b0;
      do_cmd(1'b1, start, count, t1);
      send_words(gaps, t2);
      wait_done(t3);
      to = t1 | t2 | t3;
   endtask

   task automatic run_read(input int start, input int count, input bit stall, output bit to);
      bit t1;
      exp_w.delete();
      for (int r = 0; r < count; r++)
         for (int k = 0; k < 32; k++) exp_w.push_back(ref_words[(start + r) % 32][k]);
      bus.m_ready = 1'b1;
      do_cmd(1'b0, start, count, t1);
      to = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus.done) begin
            to = 1'b0;
            break;
         end
         step();
         if (stall) bus.m_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      to = to | t1;
   endtask

   task automatic test_reset;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_row_start = '0; bus.cmd_row_count = '0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
      checks++; if (bus.ram_ena !== 1'b0) begin errors++; $display("FAIL reset_ram_ena: got %b expected 0", bus.ram_ena); end
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", bus.ram_we); end
      checks++; if (bus.ram_addr !== 5'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d expected 0", bus.ram_addr); end
      checks++; if (bus.ram_din !== '0) begin errors++; $display("FAIL reset_ram_din: got nonzero expected 0"); end
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
      checks++; if (bus.m_data !== 32'd0) begin errors++; $display("FAIL reset_m_data: got %0h expected 0", bus.m_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_write_basic;
      bit to;
      int eb;
      logic [ROW_W-1:0] row;
      eb = ev_addr.size();
      run_write(0, 1, 1'b0, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL wr_basic_timeout: got timeout expected done"); end
      checks++; if (done_cyc - acc_cyc !== 34) begin errors++; $display("FAIL wr_basic_done_lat: got %0d expected 34", done_cyc - acc_cyc); end
      checks++;
      if (ev_addr.size() - eb !== 1) begin
         errors++; $display("FAIL wr_basic_ram_cycles: got %0d expected 1", ev_addr.size() - eb);
      end else begin
         checks++; if (ev_we[eb] !== 1'b1 || ev_addr[eb] !== 5'd0) begin errors++; $display("FAIL wr_basic_addr: got we=%b addr=%0d expected we=1 addr=0", ev_we[eb], ev_addr[eb]); end
         checks++; if (ev_cyc[eb] - acc_cyc !== 33) begin errors++; $display("FAIL wr_basic_write_lat: got %0d expected 33", ev_cyc[eb] - acc_cyc); end
         row = ev_din[eb];
         for (int k = 0; k < 32; k++) begin
            checks++; if (word_slice(row, k) !== 32'(k)) begin errors++; $display("FAIL wr_basic_word%0d: got %0h expected %0h", k, word_slice(row, k), k); end
         end
      end
      step();
      checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL wr_basic_ready_after_done: got ready=%b busy=%b expected 1 0", bus.cmd_ready, bus.busy); end
   endtask

   task automatic test_read_stall;
      bit to;
      int eb, ob, sv;
      eb = ev_addr.size(); ob = out_q.size(); sv = stall_viol;
      run_read(0, 1, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL rd_stall_timeout: got timeout expected done"); end
      checks++;
      if (out_q.size() - ob !== 32) begin
         errors++; $display("FAIL rd_stall_count: got %0d expected 32", out_q.size() - ob);
      end else begin
         for (int k = 0; k < 32; k++) begin
            checks++; if (out_q[ob + k] !== exp_w[k]) begin errors++; $display("FAIL rd_stall_word%0d: got %0h expected %0h", k, out_q[ob + k], exp_w[k]); end
         end
      end
      checks++; if (stall_viol !== sv) begin errors++; $display("FAIL rd_stall_hold: got %0d unstable stalls expected 0", stall_viol - sv); end
      checks++; if (first_mv_cyc - acc_cyc !== 3) begin errors++; $display("FAIL rd_first_valid_lat: got %0d expected 3", first_mv_cyc - acc_cyc); end
      checks++; if (ev_addr.size() - eb !== 1 || ev_we[eb] !== 1'b0 || ev_addr[eb] !== 5'd0) begin errors++; $display("FAIL rd_stall_ram: got %0d accesses expected one read of row 0", ev_addr.size() - eb); end
   endtask

   task automatic test_wrap;
      bit to;
      int eb, ob;
      logic [ROW_W-1:0] row;
      eb = ev_addr.size();
      run_write(30, 4, 1'b0, 1'b0, to);
      checks++; if (to) begin errors++; $display("FAIL wrap_wr_timeout: got timeout expected done"); end
      checks++; if (done_cyc - acc_cyc !== 4 * 33 + 1) begin errors++; $display("FAIL wrap_wr_done_lat: got %0d expected %0d", done_cyc - acc_cyc, 4 * 33 + 1); end
      checks++;
      if (ev_addr.size() - eb !== 4) begin
         errors++; $display("FAIL wrap_wr_count: got %0d expected 4", ev_addr.size() - eb);
      end else begin
         for (int r = 0; r < 4; r++) begin
            checks++; if (ev_we[eb + r] !== 1'b1 || ev_addr[eb + r] !== 5'((30 + r) % 32)) begin errors++; $display("FAIL wrap_wr_addr%0d: got %0d expected %0d", r, ev_addr[eb + r], (30 + r) % 32); end
            row = ev_din[eb + r];
            for (int k = 0; k < 32; k++) begin
               checks++; if (word_slice(row, k) !== exp_w[r * 32 + k]) begin errors++; $display("FAIL wrap_wr_r%0d_w%0d: got %0h expected %0h", r, k, word_slice(row, k), exp_w[r * 32 + k]); end
            end
         end
      end
      step();
      eb = ev_addr.size(); ob = out_q.size();
      run_read(30, 4, 1'b0, to);
      checks++; if (to) begin errors++; $display("FAIL wrap_rd_timeout: got timeout expected done"); end
      checks++; if (done_cyc - acc_cyc !== 1 + 34 * 4) begin errors++; $display("FAIL wrap_rd_done_lat: got %0d expected %0d", done_cyc - acc_cyc, 1 + 34 * 4); end
      checks++;
      if (out_q.size() - ob !== 128) begin
         errors++; $display("FAIL wrap_rd_count: got %0d expected 128", out_q.size() - ob);
      end else begin
         for (int i = 0; i < 128; i++) begin
            checks++; if (out_q[ob + i] !== exp_w[i]) begin errors++; $display("FAIL wrap_rd_word%0d: got %0h expected %0h", i, out_q[ob + i], exp_w[i]); end
         end
      end
      checks++;
      if (ev_addr.size() - eb !== 4) begin
         errors++; $display("FAIL wrap_rd_ram_count: got %0d expected 4", ev_addr.size() - eb);
      end else begin
         for (int r = 0; r < 4; r++) begin
            checks++; if (ev_we[eb + r] !== 1'b0 || ev_addr[eb + r] !== 5'((30 + r) % 32)) begin errors++; $display("FAIL wrap_rd_addr%0d: got %0d expected %0d", r, ev_addr[eb + r], (30 + r) % 32); end
         end
      end
      step();
   endtask

   task automatic test_zero_count;
      bit to;
      int eb, ob;
      for (int wr = 0; wr < 2; wr++) begin
         eb = ev_addr.size(); ob = out_q.size();
         if (wr == 1) run_write(3, 0, 1'b0, 1'b0, to);
         else         run_read(7, 0, 1'b0, to);
         checks++; if (to) begin errors++; $display("FAIL zero_timeout_wr%0d: got timeout expected done", wr); end
         checks++; if (done_cyc - acc_cyc !== 1) begin errors++; $display("FAIL zero_done_lat_wr%0d: got %0d expected 1", wr, done_cyc - acc_cyc); end
         checks++; if (ev_addr.size() !== eb || out_q.size() !== ob) begin errors++; $display("FAIL zero_no_access_wr%0d: got %0d ram %0d words expected 0 0", wr, ev_addr.size() - eb, out_q.size() - ob); end
         step();
         checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_wr%0d: got %b expected 1", wr, bus.cmd_ready); end
      end
   endtask

   task automatic test_reset_mid;
      bit to, t1;
      int eb, ob;
      logic [ROW_W-1:0] row;
      eb = ev_addr.size();
      tx_q.delete();
      for (int k = 0; k < 10; k++) tx_q.push_back(32'hDEAD_0000 | 32'(k));
      do_cmd(1'b1, 5, 2, t1);
      send_words(1'b0, to);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.ram_din !== '0) begin errors++; $display("FAIL mid_reset_state: got busy=%b s_ready=%b expected 0 0 and clear row", bus.busy, bus.s_ready); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (ev_addr.size() !== eb) begin errors++; $display("FAIL mid_reset_no_write: got %0d accesses expected 0", ev_addr.size() - eb); end
      run_write(5, 1, 1'b0, 1'b0, to);
      checks++; if (to | t1) begin errors++; $display("FAIL mid_reset_timeout: got timeout expected done"); end
      checks++;
      if (ev_addr.size() - eb !== 1 || ev_addr[eb] !== 5'd5 || ev_we[eb] !== 1'b1) begin
         errors++; $display("FAIL mid_reset_write: got %0d accesses expected one write of row 5", ev_addr.size() - eb);
      end else begin
         row = ev_din[eb];
         for (int k = 0; k < 32; k++) begin
            checks++; if (word_slice(row, k) !== exp_w[k]) begin errors++; $display("FAIL mid_reset_word%0d: got %0h expected %0h", k, word_slice(row, k), exp_w[k]); end
         end
      end
      step();
      ob = out_q.size();
      run_read(5, 1, 1'b0, to);
      checks++;
      if (out_q.size() - ob !== 32) begin
         errors++; $display("FAIL mid_reset_readback_count: got %0d expected 32", out_q.size() - ob);
      end else begin
         for (int k = 0; k < 32; k++) begin
            checks++; if (out_q[ob + k] !== exp_w[k]) begin errors++; $display("FAIL mid_reset_readback%0d: got %0h expected %0h", k, out_q[ob + k], exp_w[k]); end
         end
      end
      step();
   endtask

   task automatic test_gaps;
      bit to;
      int eb, ob, sc, srv, sv;
      logic [ROW_W-1:0] row;
      eb = ev_addr.size(); sc = s_cnt; srv = sready_viol;
      run_write(10, 2, 1'b1, 1'b0, to);
      checks++; if (to) begin errors++; $display("FAIL gaps_timeout: got timeout expected done"); end
      checks++; if (s_cnt - sc !== 64) begin errors++; $display("FAIL gaps_accepted: got %0d expected 64", s_cnt - sc); end
      checks++; if (sready_viol !== srv) begin errors++; $display("FAIL gaps_s_ready_in_write: got %0d expected 0", sready_viol - srv); end
      checks++;
      if (ev_addr.size() - eb !== 2) begin
         errors++; $display("FAIL gaps_write_count: got %0d expected 2", ev_addr.size() - eb);
      end else begin
         for (int r = 0; r < 2; r++) begin
            checks++; if (ev_we[eb + r] !== 1'b1 || ev_addr[eb + r] !== 5'(10 + r)) begin errors++; $display("FAIL gaps_addr%0d: got %0d expected %0d", r, ev_addr[eb + r], 10 + r); end
            row = ev_din[eb + r];
            for (int k = 0; k < 32; k++) begin
               checks++; if (word_slice(row, k) !== exp_w[r * 32 + k]) begin errors++; $display("FAIL gaps_r%0d_w%0d: got %0h expected %0h", r, k, word_slice(row, k), exp_w[r * 32 + k]); end
            end
         end
      end
      step();
      ob = out_q.size(); sv = stall_viol;
      run_read(10, 2, 1'b1, to);
      checks++;
      if (to || out_q.size() - ob !== 64) begin
         errors++; $display("FAIL gaps_readback_count: got %0d expected 64", out_q.size() - ob);
      end else begin
         for (int i = 0; i < 64; i++) begin
            checks++; if (out_q[ob + i] !== exp_w[i]) begin errors++; $display("FAIL gaps_readback%0d: got %0h expected %0h", i, out_q[ob + i], exp_w[i]); end
         end
      end
      checks++; if (stall_viol !== sv) begin errors++; $display("FAIL gaps_read_hold: got %0d unstable stalls expected 0", stall_viol - sv); end
      step();
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_stall();
      test_wrap();
      test_zero_count();
      test_reset_mid();
      test_gaps();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end
endmodule
